// File: rtl/lab4_mcore_cache_bank_endpoint.sv
// Bank-side network endpoint: forwards network requests to a cache bank and
// re-tags the bank's in-order responses with the requester id for the response network.
package lab4_mcore_cache_bank_endpoint_pkg;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    typedef struct packed {
        logic [1:0] dest;
        logic [1:0] src;
        logic [7:0] opaque;
    } net_hdr_t;

endpackage

module lab4_mcore_cache_bank_endpoint
    import lab4_mcore_cache_bank_endpoint_pkg::*;
#(
    parameter int unsigned p_bank_id      = 0,
    parameter int unsigned p_max_inflight = 4
) (
    input  logic         clk_i,
    input  logic         reset_ni,

    input  logic         netreq_val_i,
    output logic         netreq_rdy_o,
    input  net_hdr_t     netreq_hdr_i,
    input  mem_req_4B_t  netreq_payload_i,

    output logic         cachereq_val_o,
    input  logic         cachereq_rdy_i,
    output mem_req_4B_t  cachereq_msg_o,

    input  logic         cacheresp_val_i,
    output logic         cacheresp_rdy_o,
    input  mem_resp_4B_t cacheresp_msg_i,

    output logic         netresp_val_o,
    input  logic         netresp_rdy_i,
    output net_hdr_t     netresp_hdr_o,
    output mem_resp_4B_t netresp_payload_o,

    output logic [4:0]   inflight_o,
    output logic         err_orphan_o
);

    localparam int unsigned AW = (p_max_inflight > 1) ? $clog2(p_max_inflight) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(p_max_inflight);

    logic [1:0]    tag_mem [p_max_inflight];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_orphan_q, err_orphan_d;

    logic full, empty;
    logic req_fire, resp_fire, orphan;

    assign full  = (count_q == DEPTH);
    assign empty = (count_q == '0);

    // Request side sees only count and cachereq_rdy; response side only count and netresp_rdy.
    assign cachereq_val_o = netreq_val_i && !full;
    assign netreq_rdy_o   = cachereq_rdy_i && !full;
    assign cachereq_msg_o = netreq_payload_i;
    assign req_fire       = netreq_val_i && netreq_rdy_o;

    assign netresp_val_o     = cacheresp_val_i && !empty;
    assign cacheresp_rdy_o   = empty ? 1'b1 : netresp_rdy_i;
    assign netresp_payload_o = cacheresp_msg_i;
    assign resp_fire         = netresp_val_o && netresp_rdy_i;
    assign orphan            = cacheresp_val_i && empty;

    always_comb begin
        netresp_hdr_o      = '0;
        netresp_hdr_o.dest = tag_mem[rd_ptr_q];
        netresp_hdr_o.src  = 2'(p_bank_id);
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        err_orphan_d = err_orphan_q || orphan;
        if (req_fire) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (resp_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (req_fire && !resp_fire) begin
            count_d = count_q + 1'b1;
        end else if (!req_fire && resp_fire) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    // Tag contents are meaningless while count is zero, so storage needs no reset.
    always_ff @(posedge clk_i) begin
        if (req_fire) begin
            tag_mem[wr_ptr_q] <= netreq_hdr_i.src;
        end
    end

    assign inflight_o   = 5'(count_q);
    assign err_orphan_o = err_orphan_q;

    logic unused_hdr_bits;
    assign unused_hdr_bits = ^{netreq_hdr_i.dest, netreq_hdr_i.opaque};

endmodule

// File: tb/tb_lab4_mcore_cache_bank_endpoint.sv
// Randomized and directed bench for the bank endpoint, checked against a queue model of outstanding tags.
module tb_lab4_mcore_cache_bank_endpoint;
    import lab4_mcore_cache_bank_endpoint_pkg::*;

    localparam int DEPTH   = 4;
    localparam int BANK_ID = 1;

    logic         clk_i = 1'b0;
    logic         reset_ni = 1'b0;
    logic         netreq_val_i = 1'b0;
    logic         netreq_rdy_o;
    net_hdr_t     netreq_hdr_i = '0;
    mem_req_4B_t  netreq_payload_i = '0;
    logic         cachereq_val_o;
    logic         cachereq_rdy_i = 1'b0;
    mem_req_4B_t  cachereq_msg_o;
    logic         cacheresp_val_i = 1'b0;
    logic         cacheresp_rdy_o;
    mem_resp_4B_t cacheresp_msg_i = '0;
    logic         netresp_val_o;
    logic         netresp_rdy_i = 1'b0;
    net_hdr_t     netresp_hdr_o;
    mem_resp_4B_t netresp_payload_o;
    logic [4:0]   inflight_o;
    logic         err_orphan_o;

    lab4_mcore_cache_bank_endpoint #(.p_bank_id(BANK_ID), .p_max_inflight(DEPTH)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .netreq_val_i(netreq_val_i), .netreq_rdy_o(netreq_rdy_o),
        .netreq_hdr_i(netreq_hdr_i), .netreq_payload_i(netreq_payload_i),
        .cachereq_val_o(cachereq_val_o), .cachereq_rdy_i(cachereq_rdy_i),
        .cachereq_msg_o(cachereq_msg_o),
        .cacheresp_val_i(cacheresp_val_i), .cacheresp_rdy_o(cacheresp_rdy_o),
        .cacheresp_msg_i(cacheresp_msg_i),
        .netresp_val_o(netresp_val_o), .netresp_rdy_i(netresp_rdy_i),
        .netresp_hdr_o(netresp_hdr_o), .netresp_payload_o(netresp_payload_o),
        .inflight_o(inflight_o), .err_orphan_o(err_orphan_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference: ids of requesters awaiting a response, oldest first.
    logic [1:0] q_tags[$];
    logic       m_err = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;

    function automatic net_hdr_t exp_hdr();
        net_hdr_t h;
        h = '0;
        h.src = 2'(BANK_ID);
        if (q_tags.size() != 0) h.dest = q_tags[0];
        return h;
    endfunction

    task automatic drive(input logic nv, input logic [1:0] src, input logic crdy,
                         input logic rv, input logic [31:0] data, input logic nrr);
        logic [127:0] r;
        netreq_val_i = nv;
        netreq_hdr_i = '0;
        netreq_hdr_i.src = src;
        netreq_hdr_i.dest = 2'(BANK_ID);
        netreq_hdr_i.opaque = 8'($urandom());
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        netreq_payload_i = r[$bits(mem_req_4B_t)-1:0];
        cachereq_rdy_i = crdy;
        cacheresp_val_i = rv;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        cacheresp_msg_i = r[$bits(mem_resp_4B_t)-1:0];
        cacheresp_msg_i.data = data;
        netresp_rdy_i = nrr;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic tick();
        bit rf, pf, orph;
        @(posedge clk_i);
        rf   = netreq_val_i && cachereq_rdy_i && (q_tags.size() < DEPTH);
        pf   = cacheresp_val_i && netresp_rdy_i && (q_tags.size() != 0);
        orph = cacheresp_val_i && (q_tags.size() == 0);
        if (pf) void'(q_tags.pop_front());
        if (rf) q_tags.push_back(netreq_hdr_i.src);
        if (orph) m_err = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        #2;
        drive(1'b1, 2'd1, 1'b1, 1'b1, 32'h1234, 1'b0);
        #1;
        n_checks++; if (netreq_rdy_o !== 1'b1) begin n_fail++; $display("FAIL reset_netreq_rdy got %b want 1", netreq_rdy_o); end
        n_checks++; if (cachereq_val_o !== 1'b1) begin n_fail++; $display("FAIL reset_cachereq_val got %b want 1", cachereq_val_o); end
        n_checks++; if (netresp_val_o !== 1'b0) begin n_fail++; $display("FAIL reset_netresp_val got %b want 0", netresp_val_o); end
        n_checks++; if (cacheresp_rdy_o !== 1'b1) begin n_fail++; $display("FAIL reset_cacheresp_rdy got %b want 1", cacheresp_rdy_o); end
        n_checks++; if (inflight_o !== 5'd0) begin n_fail++; $display("FAIL reset_inflight got %0d want 0", inflight_o); end
        n_checks++; if (err_orphan_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err_orphan_o); end
        idle();
        @(negedge clk_i);
        reset_ni = 1'b1;
        tick();
        $display("test_reset done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_single();
        drive(1'b1, 2'd2, 1'b1, 1'b0, 32'h0, 1'b1);
        @(negedge clk_i);
        n_checks++; if (cachereq_val_o !== 1'b1 || netreq_rdy_o !== 1'b1) begin n_fail++; $display("FAIL single_req_hs got val=%b rdy=%b want 1/1", cachereq_val_o, netreq_rdy_o); end
        n_checks++; if (cachereq_msg_o !== netreq_payload_i) begin n_fail++; $display("FAIL single_req_msg got %h want %h", cachereq_msg_o, netreq_payload_i); end
        tick();
        n_checks++; if (inflight_o !== 5'd1) begin n_fail++; $display("FAIL single_inflight1 got %0d want 1", inflight_o); end
        idle();
        tick();
        drive(1'b0, 2'd0, 1'b1, 1'b1, 32'hCAFE0001, 1'b1);
        @(negedge clk_i);
        n_checks++; if (netresp_val_o !== 1'b1) begin n_fail++; $display("FAIL single_resp_val got %b want 1", netresp_val_o); end
        n_checks++; if (netresp_hdr_o.dest !== 2'd2 || netresp_hdr_o.src !== 2'd1 || netresp_hdr_o.opaque !== 8'd0) begin n_fail++; $display("FAIL single_resp_hdr got %h want dest=2 src=1 opaque=0", netresp_hdr_o); end
        n_checks++; if (netresp_payload_o !== cacheresp_msg_i || netresp_payload_o.data !== 32'hCAFE0001) begin n_fail++; $display("FAIL single_resp_payload got %h want %h", netresp_payload_o, cacheresp_msg_i); end
        tick();
        n_checks++; if (inflight_o !== 5'd0) begin n_fail++; $display("FAIL single_inflight0 got %0d want 0", inflight_o); end
        idle();
        $display("test_single done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), 1'b1, 1'b0, 32'h0, 1'b1);
            tick();
        end
        n_checks++; if (inflight_o !== 5'd4) begin n_fail++; $display("FAIL fill_inflight got %0d want 4", inflight_o); end
        drive(1'b1, 2'd3, 1'b1, 1'b0, 32'h0, 1'b1);
        @(negedge clk_i);
        n_checks++; if (netreq_rdy_o !== 1'b0 || cachereq_val_o !== 1'b0) begin n_fail++; $display("FAIL fill_stall got rdy=%b val=%b want 0/0", netreq_rdy_o, cachereq_val_o); end
        tick();
        for (int i = 0; i < 4; i++) begin
            // The first release keeps a request pending: a departing response must not free the slot the same cycle.
            drive(i == 0, 2'd3, 1'b1, 1'b1, 32'(i), 1'b1);
            @(negedge clk_i);
            n_checks++; if (netresp_val_o !== 1'b1 || netresp_hdr_o.dest !== 2'(i)) begin n_fail++; $display("FAIL fill_release%0d got val=%b dest=%0d want 1/%0d", i, netresp_val_o, netresp_hdr_o.dest, i); end
            if (i == 0) begin
                n_checks++; if (netreq_rdy_o !== 1'b0) begin n_fail++; $display("FAIL fill_no_bypass got rdy=%b want 0", netreq_rdy_o); end
            end
            tick();
        end
        n_checks++; if (inflight_o !== 5'd0) begin n_fail++; $display("FAIL fill_drained got %0d want 0", inflight_o); end
        idle();
        $display("test_fill done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_backpressure();
        drive(1'b1, 2'd3, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'd0, 1'b1, 1'b1, 32'hBEEF0000, 1'b0);
            @(negedge clk_i);
            n_checks++; if (cacheresp_rdy_o !== 1'b0 || netresp_val_o !== 1'b1 || netresp_hdr_o.dest !== 2'd3) begin n_fail++; $display("FAIL bp_hold%0d got rdy=%b val=%b dest=%0d want 0/1/3", i, cacheresp_rdy_o, netresp_val_o, netresp_hdr_o.dest); end
            tick();
            n_checks++; if (inflight_o !== 5'd1) begin n_fail++; $display("FAIL bp_inflight%0d got %0d want 1", i, inflight_o); end
        end
        drive(1'b0, 2'd0, 1'b1, 1'b1, 32'hBEEF0000, 1'b1);
        @(negedge clk_i);
        n_checks++; if (cacheresp_rdy_o !== 1'b1 || netresp_hdr_o.dest !== 2'd3) begin n_fail++; $display("FAIL bp_release got rdy=%b dest=%0d want 1/3", cacheresp_rdy_o, netresp_hdr_o.dest); end
        tick();
        n_checks++; if (inflight_o !== 5'd0) begin n_fail++; $display("FAIL bp_drained got %0d want 0", inflight_o); end
        idle();
        $display("test_backpressure done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_simul_push_pop();
        drive(1'b1, 2'd1, 1'b1, 1'b0, 32'h0, 1'b1); tick();
        drive(1'b1, 2'd2, 1'b1, 1'b0, 32'h0, 1'b1); tick();
        // Six pushes: pointers cross the 3->0 wrap several times.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 2'($urandom_range(0, 3)), 1'b1, 1'b1, $urandom(), 1'b1);
            @(negedge clk_i);
            n_checks++; if (netresp_val_o !== 1'b1 || netresp_hdr_o !== exp_hdr()) begin n_fail++; $display("FAIL simul_head%0d got %h want %h", i, netresp_hdr_o, exp_hdr()); end
            tick();
            n_checks++; if (inflight_o !== 5'd2) begin n_fail++; $display("FAIL simul_count%0d got %0d want 2", i, inflight_o); end
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 2'd0, 1'b1, 1'b1, $urandom(), 1'b1);
            @(negedge clk_i);
            n_checks++; if (netresp_hdr_o !== exp_hdr()) begin n_fail++; $display("FAIL simul_drain%0d got %h want %h", i, netresp_hdr_o, exp_hdr()); end
            tick();
        end
        idle();
        $display("test_simul_push_pop done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_orphan();
        drive(1'b0, 2'd0, 1'b1, 1'b1, 32'hDEAD, 1'b0);
        @(negedge clk_i);
        n_checks++; if (cacheresp_rdy_o !== 1'b1 || netresp_val_o !== 1'b0) begin n_fail++; $display("FAIL orphan_hs got rdy=%b val=%b want 1/0", cacheresp_rdy_o, netresp_val_o); end
        n_checks++; if (err_orphan_o !== 1'b0) begin n_fail++; $display("FAIL orphan_early got %b want 0", err_orphan_o); end
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            n_checks++; if (err_orphan_o !== 1'b1) begin n_fail++; $display("FAIL orphan_sticky%0d got %b want 1", i, err_orphan_o); end
            tick();
        end
        $display("test_orphan done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'(i + 1), 1'b1, 1'b0, 32'h0, 1'b1);
            tick();
        end
        n_checks++; if (inflight_o !== 5'd3) begin n_fail++; $display("FAIL areset_pre got %0d want 3", inflight_o); end
        #2;
        reset_ni = 1'b0;
        #1;
        n_checks++; if (inflight_o !== 5'd0 || err_orphan_o !== 1'b0) begin n_fail++; $display("FAIL areset_immediate got inflight=%0d err=%b want 0/0", inflight_o, err_orphan_o); end
        q_tags.delete();
        m_err = 1'b0;
        idle();
        @(negedge clk_i);
        reset_ni = 1'b1;
        tick();
        drive(1'b0, 2'd0, 1'b1, 1'b1, 32'h5, 1'b1);
        @(negedge clk_i);
        n_checks++; if (netresp_val_o !== 1'b0 || cacheresp_rdy_o !== 1'b1) begin n_fail++; $display("FAIL areset_orphan got val=%b rdy=%b want 0/1", netresp_val_o, cacheresp_rdy_o); end
        tick();
        idle();
        $display("test_async_reset done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0, $urandom(), $urandom_range(0, 3) != 0);
            @(negedge clk_i);
            n_checks++; if (cachereq_val_o !== (netreq_val_i && q_tags.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_creq_val c=%0d got %b", c, cachereq_val_o); end
            n_checks++; if (netreq_rdy_o !== (cachereq_rdy_i && q_tags.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_nreq_rdy c=%0d got %b", c, netreq_rdy_o); end
            n_checks++; if (cachereq_msg_o !== netreq_payload_i) begin n_fail++; $display("FAIL rnd_creq_msg c=%0d got %h want %h", c, cachereq_msg_o, netreq_payload_i); end
            n_checks++; if (netresp_val_o !== (cacheresp_val_i && q_tags.size() != 0)) begin n_fail++; $display("FAIL rnd_nresp_val c=%0d got %b", c, netresp_val_o); end
            n_checks++; if (cacheresp_rdy_o !== ((q_tags.size() == 0) ? 1'b1 : netresp_rdy_i)) begin n_fail++; $display("FAIL rnd_cresp_rdy c=%0d got %b", c, cacheresp_rdy_o); end
            if (q_tags.size() != 0) begin
                n_checks++; if (netresp_hdr_o !== exp_hdr()) begin n_fail++; $display("FAIL rnd_hdr c=%0d got %h want %h", c, netresp_hdr_o, exp_hdr()); end
            end
            n_checks++; if (netresp_payload_o !== cacheresp_msg_i) begin n_fail++; $display("FAIL rnd_payload c=%0d got %h want %h", c, netresp_payload_o, cacheresp_msg_i); end
            n_checks++; if (inflight_o !== 5'(q_tags.size()) || err_orphan_o !== m_err) begin n_fail++; $display("FAIL rnd_state c=%0d got inflight=%0d err=%b want %0d/%b", c, inflight_o, err_orphan_o, q_tags.size(), m_err); end
            tick();
        end
        idle();
        $display("test_random done: checks=%0d failures=%0d", n_checks, n_fail);
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_backpressure();
        test_simul_push_pop();
        test_orphan();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
